// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code decoder family: FSM state encoding,
// the widest supported word, and a one-bit-step helper that the encoder-side
// bench reuses.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } gray_state_e;

  localparam int GRAY_MAX_WIDTH = 32;

  // True when the two words differ in exactly one bit position.
  function automatic logic hamming_is_one(input logic [GRAY_MAX_WIDTH-1:0] a,
                                          input logic [GRAY_MAX_WIDTH-1:0] b);
    return ($countones(a ^ b) == 1);
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Watches the stream of accepted Gray words and raises a sticky flag whenever
// two consecutive words are not exactly one bit apart.  Used by
// gray_to_binary_decoder only when GRAY_STEP_CHECK_EN is defined.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] gray,
  output logic             step_err
);

  logic [WIDTH-1:0] prev_gray;
  logic             first_seen;

  // Compare each accepted word against the previous one; the very first word has nothing to compare to.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray  <= '0;
      first_seen <= 1'b0;
      step_err   <= 1'b0;
    end else if (accept) begin
      if (first_seen &&
          !hamming_is_one(GRAY_MAX_WIDTH'(gray), GRAY_MAX_WIDTH'(prev_gray))) begin
        step_err <= 1'b1;
      end
      prev_gray  <= gray;
      first_seen <= 1'b1;
    end
  end

endmodule

// File: rtl/gray_to_binary_decoder.sv
// Iterative Gray-to-binary decoder.  A Gray word is taken over a valid/ready
// handshake and resolved MSB-first, one bit per clock, then presented on an
// output valid/ready handshake.
// Optional build macro GRAY_STEP_CHECK_EN adds a sticky step_err flag that
// trips when consecutive accepted words are not one Gray step apart; without
// it step_err is tied low.
module gray_to_binary_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             busy,
  output logic             step_err
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_DECODE = 2'(DECODE);
  localparam logic [1:0] S_DONE   = 2'(DONE);

  // The index only has to reach WIDTH-2; keep at least one bit for WIDTH=1/2.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LOAD = (WIDTH > 1) ? IW'(WIDTH - 2) : '0;

  logic [1:0]       state;
  logic [WIDTH-1:0] gray_q;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] bin_next;
  logic             accept;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_DECODE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;

  // Resolve the bit selected by idx from the already-resolved bit above it.
  always_comb begin
    bin_next           = out_bin;
    bin_next[WIDTH-1]  = gray_q[WIDTH-1];
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (idx == IW'(i)) begin
        bin_next[i] = out_bin[i+1] ^ gray_q[i];
      end
    end
  end

  // Handshake FSM and bit-serial datapath; reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gray_q  <= '0;
      out_bin <= '0;
      idx     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            gray_q           <= in_gray;
            out_bin          <= '0;
            out_bin[WIDTH-1] <= in_gray[WIDTH-1];
            idx              <= IDX_LOAD;
            state            <= (WIDTH == 1) ? S_DONE : S_DECODE;
          end
        end
        S_DECODE: begin
          out_bin <= bin_next;
          if (idx == '0) begin
            state <= S_DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef GRAY_STEP_CHECK_EN
  gray_step_checker #(
    .WIDTH(WIDTH)
  ) u_step_checker (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .gray    (in_gray),
    .step_err(step_err)
  );
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: doc/gray_to_binary_decoder.md
Name: gray_to_binary_decoder

Overview:
Iterative Gray-to-binary decoder, the inverse of the team's binary-to-Gray encoder. Accepts one WIDTH-bit Gray word over a valid/ready handshake and resolves it MSB-first, one bit per clock. Presents the binary result on an output valid/ready handshake. Sits on the receive side of Gray-coded pointer and counter paths, for example after a CDC synchroniser.

Parameters:
WIDTH, 3, bit width of the Gray input and binary output; legal range 1..32.

Ports:
clk  input  1  single clock; all logic on the rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  Gray word on in_gray is valid
in_ready  output  1  block can accept a word
in_gray  input  WIDTH  Gray-coded input word
out_valid  output  1  out_bin holds a completed result
out_ready  input  1  downstream accepts the result
out_bin  output  WIDTH  decoded binary word
busy  output  1  decode in progress (state DECODE)
step_err  output  1  Gray step violation flag (only with the optional feature; tied 0 without it)

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1; out_valid=0; busy=0; out_bin=0; internal Gray register=0; bit index=0; step_err=0. Reset wins over every other event, including mid-DECODE and in DONE with out_valid=1; any partial result is discarded.
- States: IDLE, DECODE, DONE.
  - in_ready=1 only in IDLE.
  - busy=1 only in DECODE.
  - out_valid=1 only in DONE.
- IDLE, on the edge where in_valid=1 (the accept edge):
  - latch in_gray into the Gray register
  - set out_bin[WIDTH-1]=in_gray[WIDTH-1]; clear the other out_bin bits
  - if WIDTH==1: go to DONE; else load index=WIDTH-2 and go to DECODE.
- DECODE, each edge:
  - out_bin[idx] = out_bin[idx+1] XOR gray[idx]
  - if idx==0: go to DONE; else idx decrements by 1.
- Latency: out_valid is high from the (WIDTH-1)th edge after the accept edge. Throughput is one word per WIDTH+1 cycles minimum.
- DONE:
  - out_bin and out_valid are held stable while out_ready=0; unlimited backpressure.
  - On the edge with out_ready=1: go to IDLE and drop out_valid.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
- in_gray and in_valid are ignored outside IDLE. Changes to in_gray after the accept edge do not affect the result.
- Wrap-around: all-ones Gray decodes normally (e.g. WIDTH=3, 100 -> 111). No arithmetic overflow is possible.
- out_bin must be valid-qualified. Intermediate bits are visible during DECODE and carry no meaning until DONE.

Optional Feature:
Macro GRAY_STEP_CHECK_EN.
- Defined:
  - Keep a prev_gray register (reset 0) and a first_seen flag (reset 0).
  - On each accept edge, when first_seen=1 and the Hamming distance between in_gray and prev_gray is not exactly 1, set step_err=1.
  - Then update prev_gray to in_gray and set first_seen=1.
  - step_err is sticky; it clears only on rst.
  - A repeated identical word (distance 0) is also an error.
- Not defined: step_err is a constant 0. No prev_gray or first_seen logic is generated; the port remains.

Decomposition:
- Shared package gray_pkg:
  - state enum (IDLE=2'd0, DECODE=2'd1, DONE=2'd2)
  - GRAY_MAX_WIDTH=32 constant
  - a hamming_is_one(a,b) function, for reuse by the encoder-side bench
- Sub-module gray_step_checker holds prev_gray, first_seen and step_err. It is instantiated only under GRAY_STEP_CHECK_EN.
- The datapath and FSM stay in the top module.

Test Plan:
- WIDTH=4, rst for 2 cycles -> in_ready=1, out_valid=0, out_bin=0, busy=0, step_err=0.
- WIDTH=4, accept 4'b0110, out_ready=1 -> out_valid rises 3 edges after accept with out_bin=4'b0100, held 1 cycle, then in_ready=1.
- WIDTH=4, accept 4'b1000, out_ready=0 for 5 cycles -> out_bin=4'b1111 and out_valid held stable throughout; in_ready=0 until the edge where out_ready goes to 1.
- WIDTH=4, assert rst one edge after accepting 4'b0110 -> next cycle IDLE, out_valid=0, out_bin=0; then accept 4'b0001 -> out_bin=4'b0001.
- WIDTH=1 and WIDTH=3, sweep all Gray codes -> out_bin equals the binary index. Latency: 0 edges after accept for WIDTH=1, 2 edges for WIDTH=3.
- GRAY_STEP_CHECK_EN, WIDTH=4, accept 0110, 0111, 0101, then 1000 -> step_err stays 0 through 0101, goes 1 after the 1000 accept edge, and stays 1 until rst.
